// File: rtl/wb_seq_pkg.sv
// Shared types and constants for the accumulator writeback sequencer.
// Optional IN-port timeout is enabled with WB_SEQ_IN_TIMEOUT_EN.
package wb_seq_pkg;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_MDR  = 3'd1,
      OP_ALU  = 3'd2,
      OP_IMM  = 3'd3,
      OP_LLI  = 3'd4,
      OP_SLLI = 3'd5,
      OP_IN   = 3'd6,
      OP_OUT  = 3'd7
   } op_kind_t;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WRITE    = 3'd1,
      S_WAIT_IN  = 3'd2,
      S_OUT_LOAD = 3'd3,
      S_OUT_HOLD = 3'd4
   } state_t;

   localparam logic [1:0] REGSRC_MDR = 2'd0;
   localparam logic [1:0] REGSRC_ALU = 2'd1;
   localparam logic [1:0] REGSRC_IMM = 2'd2;
   localparam logic [1:0] REGSRC_IN  = 2'd3;

   // LLI/SLLI take their operand from the immediate path.
   function automatic logic [1:0] regsrc_for(op_kind_t kind);
      case (kind)
         OP_ALU:                  return REGSRC_ALU;
         OP_IMM, OP_LLI, OP_SLLI: return REGSRC_IMM;
         default:                 return REGSRC_MDR;
      endcase
   endfunction

endpackage

// File: rtl/wb_in_timer.sv
// 8-bit WAIT_IN cycle counter with clear, enable and expire-at-limit.
// Only instantiated when WB_SEQ_IN_TIMEOUT_EN is defined.
module wb_in_timer #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expire
);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   assign expire = (count == 8'(LIMIT));

endmodule

// File: rtl/writeback_sequencer.sv
// Multicycle writeback controller: accumulator write, INPUT and output handshakes.
// Define WB_SEQ_IN_TIMEOUT_EN to abort WAIT_IN after TIMEOUT_CYCLES idle cycles.
module writeback_sequencer
   import wb_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       op_valid,
   input  logic [2:0] op_kind,
   output logic       op_ready,
   input  logic       in_valid,
   output logic       in_ack,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] regsrc,
   output logic       regw,
   output logic       isLLI,
   output logic       isSLLI,
   output logic       outputw,
   output logic       done,
   output logic       in_timeout
);

   state_t   state;
   op_kind_t kind;
   logic     expire;

`ifdef WB_SEQ_IN_TIMEOUT_EN
   logic timer_clear;
   logic timer_en;

   // Counter only runs while waiting with no data; any exit clears it.
   assign timer_clear = (state != S_WAIT_IN) || in_valid || expire;
   assign timer_en    = (state == S_WAIT_IN) && !in_valid && !expire;

   wb_in_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_in_timer (
      .clk    (CLK),
      .reset  (reset),
      .clear  (timer_clear),
      .en     (timer_en),
      .expire (expire)
   );
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES[7:0];
   assign expire             = 1'b0;
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         kind  <= OP_NONE;
      end else begin
         case (state)
            S_IDLE: begin
               if (op_valid) begin
                  kind <= op_kind_t'(op_kind);
                  case (op_kind_t'(op_kind))
                     OP_IN:   state <= S_WAIT_IN;
                     OP_OUT:  state <= S_OUT_LOAD;
                     default: state <= S_WRITE;
                  endcase
               end
            end
            S_WRITE:    state <= S_IDLE;
            S_WAIT_IN: begin
               if (in_valid || expire) begin
                  state <= S_IDLE;
               end
            end
            S_OUT_LOAD: state <= S_OUT_HOLD;
            S_OUT_HOLD: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default:    state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      op_ready   = 1'b0;
      in_ack     = 1'b0;
      out_valid  = 1'b0;
      regsrc     = REGSRC_MDR;
      regw       = 1'b0;
      isLLI      = 1'b0;
      isSLLI     = 1'b0;
      outputw    = 1'b0;
      done       = 1'b0;
      in_timeout = 1'b0;
      case (state)
         S_IDLE: op_ready = 1'b1;
         S_WRITE: begin
            regsrc = regsrc_for(kind);
            regw   = (kind != OP_NONE);
            isLLI  = (kind == OP_LLI);
            isSLLI = (kind == OP_SLLI);
            done   = 1'b1;
         end
         S_WAIT_IN: begin
            regsrc = REGSRC_IN;
            // Arriving data takes priority over a simultaneous expiry.
            if (in_valid) begin
               regw   = 1'b1;
               in_ack = 1'b1;
               done   = 1'b1;
            end else if (expire) begin
               in_timeout = 1'b1;
               done       = 1'b1;
            end
         end
         S_OUT_LOAD: outputw = 1'b1;
         S_OUT_HOLD: begin
            out_valid = 1'b1;
            done      = out_ready;
         end
         default: ;
      endcase
   end

endmodule
